logits_sequencer: RTL
=====================

LOGITS_SEQUENCER -- requirements
Module: logits_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, bit width of one signed logit.
REQ-002 Parameter DIM, default 10, number of logits per classification vector; legal range 1..1024.
REQ-003 Parameter IDXW, default (DIM<=1)?1:$clog2(DIM), width of a class index.
REQ-004 Parameter WDOG_CYCLES, default 1024, watchdog limit in cycles; used only under LOGITS_SEQ_WDOG_EN.
REQ-005 Port clk, input, 1, single clock; all logic is synchronous to its rising edge.
REQ-006 Port reset, input, 1, synchronous active-high reset.
REQ-007 Port in_valid, input, 1, an upstream logit beat is present.
REQ-008 Port in_data, input, signed DATA_WIDTH, logit value; beats arrive in index order 0..DIM-1.
REQ-009 Port in_ready, output, 1, the sequencer accepts a beat this cycle.
REQ-010 Port am_start, output, 1, start pulse to the argmax engine.
REQ-011 Port am_vec, output, unpacked array [0:DIM-1] of signed DATA_WIDTH, the vector presented to argmax.
REQ-012 Port am_idx, input, IDXW, index result from argmax.
REQ-013 Port am_done, input, 1, argmax completion; argmax deasserts it no later than the cycle after am_start.
REQ-014 Port res_valid, output, 1, a classification result is held.
REQ-015 Port res_idx, output, IDXW, captured class index.
REQ-016 Port res_err, output, 1, the result is a watchdog timeout (constant 0 without the macro).
REQ-017 Port res_ready, input, 1, downstream consumes the result.
REQ-018 Port busy, output, 1, high in every state except COLLECT with a zero beat count.

Function
REQ-019 The FSM SHALL have states COLLECT, START, WAIT and RESULT.
REQ-020 COLLECT: in_ready=1; each beat with in_valid=1 SHALL be written to am_vec[cnt], and cnt SHALL increment.
REQ-021 Acceptance of the beat with cnt==DIM-1 SHALL move the FSM to START, and cnt SHALL be cleared to 0.
REQ-022 START SHALL last exactly one cycle, with am_start=1, and SHALL then move to WAIT; am_start SHALL be 0 in all other states.
REQ-023 am_vec SHALL be stable from START until leaving RESULT; in_ready=0 in START, WAIT and RESULT.
REQ-024 am_done SHALL be sampled only in WAIT.
REQ-025 In WAIT, am_done=1 SHALL load res_idx<=am_idx and res_err<=0, and SHALL move the FSM to RESULT.
REQ-026 Latency: am_start SHALL be high in the cycle after the last beat is accepted, and res_valid SHALL be high in the cycle after am_done is sampled in WAIT.
REQ-027 RESULT: res_valid=1, and res_idx/res_err SHALL be held.
REQ-028 In RESULT, res_ready=1 SHALL move the FSM to COLLECT in the next cycle, and res_valid SHALL drop in that cycle; there is no input/result overlap.
REQ-029 DIM==1: a single accepted beat SHALL go directly to START.
REQ-030 in_valid while in_ready=0 SHALL be ignored, and the beat SHALL NOT be consumed.

Reset
REQ-031 reset=1 at any clock edge SHALL force COLLECT with cnt=0, am_start=0, res_valid=0, res_idx=0, res_err=0 and the watchdog count at 0, including mid-collect and mid-WAIT.
REQ-032 am_vec contents SHALL be cleared to 0 on reset.
REQ-033 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-034 Macro LOGITS_SEQ_WDOG_EN defined: a counter SHALL be cleared on entry to WAIT and SHALL increment on each WAIT cycle.
REQ-035 With LOGITS_SEQ_WDOG_EN, when the counter reaches WDOG_CYCLES without am_done, the FSM SHALL enter RESULT with res_idx=0 and res_err=1.
REQ-036 Macro LOGITS_SEQ_WDOG_EN undefined: there SHALL be no counter, WAIT SHALL persist until am_done, and res_err SHALL be tied to 0.

Verification
REQ-037 DIM=6, stream {-3,-1,-7,-1,-2,-9} with in_valid held high, argmax model -> one am_start pulse the cycle after beat 5; res_idx=1 and res_err=0.
REQ-038 Stream {1,2,3,9,8,0} with in_valid toggling every other cycle -> am_vec matches the stream exactly; res_idx=3.
REQ-039 Hold res_ready=0 for 20 cycles in RESULT, then send 6 more beats -> in_ready=0 and res_idx stable throughout; after res_ready=1, the next vector {0,5,2,5,1,4} gives res_idx=1.
REQ-040 Assert reset after 3 beats, then send a full 6-beat vector -> vector positions 0..5 hold the new beats, and there is no spurious am_start.
REQ-041 With LOGITS_SEQ_WDOG_EN and WDOG_CYCLES=8, the argmax model never asserts am_done -> res_valid is high 9 cycles after WAIT entry, with res_err=1 and res_idx=0.
REQ-042 am_done forced high during COLLECT -> ignored; no transition occurs and res_valid=0.

Source files
------------

// File: rtl/logits_sequencer.sv
// Collects DIM signed logits, hands the vector to an argmax engine, holds the class index.
// Optional LOGITS_SEQ_WDOG_EN adds a WAIT watchdog that reports a timeout via res_err.
module logits_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int DIM         = 10,
  parameter int IDXW        = (DIM <= 1) ? 1 : $clog2(DIM),
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         in_ready,
  output logic                         am_start,
  output logic signed [DATA_WIDTH-1:0] am_vec [0:DIM-1],
  input  logic        [IDXW-1:0]       am_idx,
  input  logic                         am_done,
  output logic                         res_valid,
  output logic        [IDXW-1:0]       res_idx,
  output logic                         res_err,
  input  logic                         res_ready,
  output logic                         busy
);

  typedef enum logic [1:0] {
    COLLECT,
    START,
    WAIT,
    RESULT
  } state_t;

  localparam logic [IDXW-1:0] LAST = IDXW'(DIM - 1);

  state_t                       state_q, state_d;
  logic        [IDXW-1:0]       cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0] vec_q [0:DIM-1];
  logic signed [DATA_WIDTH-1:0] vec_d [0:DIM-1];
  logic        [IDXW-1:0]       res_idx_q, res_idx_d;

`ifdef LOGITS_SEQ_WDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDW-1:0] WDOG_LIM = WDW'(WDOG_CYCLES);

  logic           res_err_q, res_err_d;
  logic [WDW-1:0] wdog_q, wdog_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    vec_d     = vec_q;
    res_idx_d = res_idx_q;
`ifdef LOGITS_SEQ_WDOG_EN
    res_err_d = res_err_q;
    wdog_d    = wdog_q;
`endif
    unique case (state_q)
      COLLECT: begin
        if (in_valid) begin
          vec_d[cnt_q] = in_data;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = START;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      START: begin
        state_d = WAIT;
`ifdef LOGITS_SEQ_WDOG_EN
        wdog_d = '0;
`endif
      end
      WAIT: begin
        // A real completion wins over a timeout landing in the same cycle.
        if (am_done) begin
          res_idx_d = am_idx;
          state_d   = RESULT;
`ifdef LOGITS_SEQ_WDOG_EN
          res_err_d = 1'b0;
        end else if (wdog_q == WDOG_LIM) begin
          res_idx_d = '0;
          res_err_d = 1'b1;
          state_d   = RESULT;
        end else begin
          wdog_d = wdog_q + 1'b1;
`endif
        end
      end
      RESULT: begin
        if (res_ready) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= COLLECT;
      cnt_q     <= '0;
      res_idx_q <= '0;
      for (int i = 0; i < DIM; i++) vec_q[i] <= '0;
`ifdef LOGITS_SEQ_WDOG_EN
      res_err_q <= 1'b0;
      wdog_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      res_idx_q <= res_idx_d;
      vec_q     <= vec_d;
`ifdef LOGITS_SEQ_WDOG_EN
      res_err_q <= res_err_d;
      wdog_q    <= wdog_d;
`endif
    end
  end

  assign in_ready  = (state_q == COLLECT);
  assign am_start  = (state_q == START);
  assign res_valid = (state_q == RESULT);
  assign busy      = !((state_q == COLLECT) && (cnt_q == '0));
  assign res_idx   = res_idx_q;
  assign am_vec    = vec_q;

`ifdef LOGITS_SEQ_WDOG_EN
  assign res_err = res_err_q;
`else
  assign res_err = 1'b0;
`endif

endmodule
